// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, control width and a legality helper.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  // Every defined ALUControl code. Codes 01011 and 10100-11111 are undefined.
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b00001,
    ALU_AND   = 5'b00010,
    ALU_OR    = 5'b00011,
    ALU_XOR   = 5'b00100,
    ALU_SLT   = 5'b00101,
    ALU_SLL   = 5'b00110,
    ALU_SRL   = 5'b00111,
    ALU_SRA   = 5'b01000,
    ALU_SLLI  = 5'b01001,
    ALU_SRAI  = 5'b01010,
    ALU_ADDI  = 5'b01100,
    ALU_SLTI  = 5'b01101,
    ALU_SLTIU = 5'b01110,
    ALU_XORI  = 5'b01111,
    ALU_SRLI  = 5'b10000,
    ALU_ORI   = 5'b10001,
    ALU_ANDI  = 5'b10010,
    ALU_JALR  = 5'b10011
  } alu_op_e;

  // True when the code names one of the operations above.
  function automatic logic is_defined(alu_op_e op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL,
      ALU_SRL, ALU_SRA, ALU_SLLI, ALU_SRAI, ALU_ADDI, ALU_SLTI,
      ALU_SLTIU, ALU_XORI, ALU_SRLI, ALU_ORI, ALU_ANDI, ALU_JALR:
        is_defined = 1'b1;
      default:
        is_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU: ALUControl code plus two operands to result,
// zero flag and an undefined-code flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  illegal
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] sum;
  logic            lt_signed;
  logic            lt_unsigned;
  alu_op_e         op;

  assign op          = alu_op_e'(alu_ctrl);
  assign shamt       = src_b[4:0];
  assign sum         = src_a + src_b;
  assign lt_signed   = $signed(src_a) < $signed(src_b);
  assign lt_unsigned = src_a < src_b;

  // Select the operation; undefined codes yield zero and raise illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD,  ALU_ADDI:  result = sum;
      ALU_SUB:             result = src_a - src_b;
      ALU_AND,  ALU_ANDI:  result = src_a & src_b;
      ALU_OR,   ALU_ORI:   result = src_a | src_b;
      ALU_XOR,  ALU_XORI:  result = src_a ^ src_b;
      ALU_SLT,  ALU_SLTI:  result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTIU:           result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_SLL,  ALU_SLLI:  result = src_a << shamt;
      ALU_SRL,  ALU_SRLI:  result = src_a >> shamt;
      ALU_SRA,  ALU_SRAI:  result = $unsigned($signed(src_a) >>> shamt);
      ALU_JALR:            result = sum & ~{{(XLEN-1){1'b0}}, 1'b1};
      default: begin
        result  = '0;
        illegal = !is_defined(op);
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ID/EX register, ALU evaluation and EX/MEM register.
//
// Pipeline control: there is no valid/ready handshake. id_valid qualifies the
// decode-side payload on every edge; the hazard unit's stall holds ID/EX and
// inserts a bubble (valid=0, result/flags=0) into EX/MEM, while flush kills
// the instruction entering ID/EX. With both asserted, ID/EX is flushed and
// EX/MEM still takes a bubble.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic [XLEN-1:0]       id_src_a,
  input  logic [XLEN-1:0]       id_src_b,
  input  logic [XLEN-1:0]       id_store_data,
  input  logic [4:0]            id_rd,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [4:0]            ex_rd,
  output logic                  mem_valid,
  output logic [XLEN-1:0]       mem_result,
  output logic                  mem_zero,
  output logic                  mem_illegal,
  output logic [XLEN-1:0]       mem_store_data,
  output logic [4:0]            mem_rd,
  output logic [CTRL_W-1:0]     mem_ctrl
);

  // ID/EX register
  logic                  ex_valid_q,  ex_valid_d;
  logic [ALU_CTRL_W-1:0] ex_op_q,     ex_op_d;
  logic [XLEN-1:0]       ex_a_q,      ex_a_d;
  logic [XLEN-1:0]       ex_b_q,      ex_b_d;
  logic [XLEN-1:0]       ex_sd_q,     ex_sd_d;
  logic [4:0]            ex_rd_q,     ex_rd_d;
  logic [CTRL_W-1:0]     ex_ctrl_q,   ex_ctrl_d;

  // EX/MEM register
  logic                  mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]       mem_res_q,   mem_res_d;
  logic                  mem_zero_q,  mem_zero_d;
  logic                  mem_ill_q,   mem_ill_d;
  logic [XLEN-1:0]       mem_sd_q,    mem_sd_d;
  logic [4:0]            mem_rd_q,    mem_rd_d;
  logic [CTRL_W-1:0]     mem_ctrl_q,  mem_ctrl_d;

  logic [XLEN-1:0]       alu_result;
  logic                  alu_zero;
  logic                  alu_illegal;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .alu_ctrl (ex_op_q),
    .src_a    (ex_a_q),
    .src_b    (ex_b_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .illegal  (alu_illegal)
  );

  // ID/EX next state: flush clears, stall holds, otherwise capture decode.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_sd_d    = ex_sd_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_op_d    = '0;
      ex_a_d     = '0;
      ex_b_d     = '0;
      ex_sd_d    = '0;
      ex_rd_d    = '0;
      ex_ctrl_d  = '0;
    end else if (!stall) begin
      ex_valid_d = id_valid;
      ex_op_d    = id_alu_ctrl;
      ex_a_d     = id_src_a;
      ex_b_d     = id_src_b;
      ex_sd_d    = id_store_data;
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_ctrl;
    end
  end

  // EX/MEM next state: stall inserts an all-zero bubble; a bubble coming
  // from ID/EX never reports illegal.
  always_comb begin
    mem_valid_d = 1'b0;
    mem_res_d   = '0;
    mem_zero_d  = 1'b0;
    mem_ill_d   = 1'b0;
    mem_sd_d    = '0;
    mem_rd_d    = '0;
    mem_ctrl_d  = '0;
    if (!stall) begin
      mem_valid_d = ex_valid_q;
      mem_res_d   = alu_result;
      mem_zero_d  = alu_zero;
      mem_ill_d   = alu_illegal & ex_valid_q;
      mem_sd_d    = ex_sd_q;
      mem_rd_d    = ex_rd_q;
      mem_ctrl_d  = ex_ctrl_q;
    end
  end

  // Both pipeline registers; reset discards anything in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_sd_q     <= '0;
      ex_rd_q     <= '0;
      ex_ctrl_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_res_q   <= '0;
      mem_zero_q  <= 1'b0;
      mem_ill_q   <= 1'b0;
      mem_sd_q    <= '0;
      mem_rd_q    <= '0;
      mem_ctrl_q  <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_sd_q     <= ex_sd_d;
      ex_rd_q     <= ex_rd_d;
      ex_ctrl_q   <= ex_ctrl_d;
      mem_valid_q <= mem_valid_d;
      mem_res_q   <= mem_res_d;
      mem_zero_q  <= mem_zero_d;
      mem_ill_q   <= mem_ill_d;
      mem_sd_q    <= mem_sd_d;
      mem_rd_q    <= mem_rd_d;
      mem_ctrl_q  <= mem_ctrl_d;
    end
  end

  assign ex_alu_ctrl    = ex_op_q;
  assign ex_rd          = ex_rd_q;
  assign mem_valid      = mem_valid_q;
  assign mem_result     = mem_res_q;
  assign mem_zero       = mem_zero_q;
  assign mem_illegal    = mem_ill_q;
  assign mem_store_data = mem_sd_q;
  assign mem_rd         = mem_rd_q;
  assign mem_ctrl       = mem_ctrl_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed cases from the test plan
// followed by randomized traffic against a behavioural pipeline model.
module tb_ex_alu_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int EXP_W  = 1 + XLEN + 1 + 1 + XLEN + 5 + CTRL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              id_valid;
  logic [4:0]        id_alu_ctrl;
  logic [XLEN-1:0]   id_src_a, id_src_b, id_store_data;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              stall, flush;
  logic [4:0]        ex_alu_ctrl, ex_rd;
  logic              mem_valid, mem_zero, mem_illegal;
  logic [XLEN-1:0]   mem_result, mem_store_data;
  logic [4:0]        mem_rd;
  logic [CTRL_W-1:0] mem_ctrl;

  ex_alu_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_alu_ctrl    (id_alu_ctrl),
    .id_src_a       (id_src_a),
    .id_src_b       (id_src_b),
    .id_store_data  (id_store_data),
    .id_rd          (id_rd),
    .id_ctrl        (id_ctrl),
    .stall          (stall),
    .flush          (flush),
    .ex_alu_ctrl    (ex_alu_ctrl),
    .ex_rd          (ex_rd),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_zero       (mem_zero),
    .mem_illegal    (mem_illegal),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_ctrl       (mem_ctrl)
  );

  // ---------------- counters / scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Model of the instruction currently sitting between the stages.
  logic              m_v;
  logic [4:0]        m_code;
  logic [XLEN-1:0]   m_a, m_b, m_sd;
  logic [4:0]        m_rd;
  logic [CTRL_W-1:0] m_ctrl;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the operation table.
  function automatic void ref_alu(input logic [4:0] code, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b,
                                  output logic [XLEN-1:0] r, output logic ill);
    int unsigned s;
    s   = b % 32;
    ill = 1'b0;
    r   = '0;
    case (code)
      5'd0,  5'd12: r = a + b;
      5'd1:         r = a - b;
      5'd2,  5'd18: r = a & b;
      5'd3,  5'd17: r = a | b;
      5'd4,  5'd15: r = a ^ b;
      5'd5,  5'd13: r = (int'(a) < int'(b)) ? 1 : 0;
      5'd14:        r = (a < b) ? 1 : 0;
      5'd6,  5'd9:  r = a * (32'd1 << s);
      5'd7,  5'd16: r = a / (32'd1 << s);
      5'd8,  5'd10: r = (a / (32'd1 << s)) | (a[XLEN-1] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      5'd19:        r = (a + b) - ((a + b) % 2);
      default:      ill = 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    m_v = 0; m_code = 0; m_a = 0; m_b = 0; m_sd = 0; m_rd = 0; m_ctrl = 0;
  endfunction

  // ---------------- driver ----------------
  // Drive one decode slot, advance one edge and compare against the model.
  task automatic issue(input logic v, input logic [4:0] code, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic st, input logic fl);
    logic [XLEN-1:0] r;
    logic            ill;
    logic [EXP_W-1:0] e;
    logic            e_v;
    id_valid      = v;
    id_alu_ctrl   = code;
    id_src_a      = a;
    id_src_b      = b;
    id_store_data = $urandom;
    id_rd         = 5'($urandom_range(0, 31));
    id_ctrl       = 8'($urandom_range(0, 255));
    stall         = st;
    flush         = fl;
    // expected EX/MEM after this edge
    ref_alu(m_code, m_a, m_b, r, ill);
    if (st || !m_v) e = '0;
    else            e = {1'b1, r, (r == 0), ill, m_sd, m_rd, m_ctrl};
    exp_q.push_back(e);
    // expected ID/EX after this edge
    if (fl) model_reset();
    else if (!st) begin
      m_v = v; m_code = code; m_a = a; m_b = b;
      m_sd = id_store_data; m_rd = id_rd; m_ctrl = id_ctrl;
    end
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    e_v = e[EXP_W-1];
    check("mem_valid", mem_valid, e_v);
    if (e_v)
      check("mem_payload", {mem_result, mem_zero, mem_illegal, mem_store_data, mem_rd, mem_ctrl},
            e[EXP_W-2:0]);
    else
      check("bubble_illegal", mem_illegal, 1'b0);
    if (st)
      check("stall_bubble", {mem_result, mem_zero}, 33'd0);
    check("ex_fields", {ex_alu_ctrl, ex_rd}, {m_code, m_rd});
  endtask

  task automatic check_zero_outputs(input string tag);
    check(tag, {ex_alu_ctrl, ex_rd, mem_valid, mem_result, mem_zero, mem_illegal,
                mem_store_data, mem_rd, mem_ctrl}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] xa, xb, qa, qb;
    reset = 1'b1;
    id_valid = 1'b1; id_alu_ctrl = 5'd0; id_src_a = 32'd5; id_src_b = 32'd7;
    id_store_data = 32'hdead_beef; id_rd = 5'd3; id_ctrl = 8'hff;
    stall = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    check_zero_outputs("reset_immediate");
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    reset = 1'b0;

    // first instruction after reset
    issue(1, 5'd0, 32'd5, 32'd7, 0, 0);
    issue(0, 5'd0, 0, 0, 0, 0);
    check("add_5_7", {mem_valid, mem_result}, {1'b1, 32'd12});

    // shifts with shamt taken from low 5 bits of 0x21
    issue(1, 5'd7, 32'h8000_0000, 32'h21, 0, 0);
    issue(1, 5'd8, 32'h8000_0000, 32'h21, 0, 0);
    check("srl", mem_result, 32'h4000_0000);
    issue(1, 5'd6, 32'h8000_0000, 32'h21, 0, 0);
    check("sra", mem_result, 32'hC000_0000);
    issue(1, 5'd5, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("sll", {mem_valid, mem_result}, {1'b1, 32'h0});

    // compares, zero flag, JALR, undefined code
    issue(1, 5'd14, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("slt", mem_result, 32'd1);
    issue(1, 5'd1, 32'h1234, 32'h1234, 0, 0);
    check("sltiu", mem_result, 32'd0);
    issue(1, 5'd19, 32'h1001, 32'h2, 0, 0);
    check("sub_zero", {mem_result, mem_zero}, {32'd0, 1'b1});
    issue(1, 5'b10101, 32'h55, 32'h66, 0, 0);
    check("jalr", mem_result, 32'h0000_1002);
    issue(0, 5'b10101, 32'h55, 32'h66, 0, 0);
    check("illegal", {mem_valid, mem_result, mem_illegal}, {1'b1, 32'd0, 1'b1});
    issue(0, 5'd0, 0, 0, 0, 0);
    check("illegal_bubble", {mem_valid, mem_illegal}, 2'b00);

    // two-cycle stall with XOR held in ID/EX
    xa = 32'hA5A5_0F0F; xb = 32'h0FF0_1234;
    issue(1, 5'd4, xa, xb, 0, 0);
    issue(1, 5'd0, 32'h1, 32'h1, 1, 0);
    check("stall_cycle1", mem_valid, 1'b0);
    issue(1, 5'd3, 32'h2, 32'h2, 1, 0);
    check("stall_cycle2", mem_valid, 1'b0);
    issue(1, 5'd3, 32'hF0, 32'h0F, 0, 0);
    check("xor_after_stall", {mem_valid, mem_result}, {1'b1, xa ^ xb});
    issue(0, 5'd0, 0, 0, 0, 0);
    check("or_after_xor", {mem_valid, mem_result}, {1'b1, 32'hFF});

    // flush+stall kills ADDI in decode; the next instruction flows normally
    qa = 32'd100; qb = 32'd58;
    issue(1, 5'd12, 32'd1, 32'd2, 1, 1);
    check("flush_stall_bubble", mem_valid, 1'b0);
    issue(1, 5'd1, qa, qb, 0, 0);
    check("addi_killed", mem_valid, 1'b0);
    issue(0, 5'd0, 0, 0, 0, 0);
    check("sub_after_flush", {mem_valid, mem_result}, {1'b1, 32'd42});

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [XLEN-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 8)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      issue(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 31)), ra, rb,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
    end

    // reset mid-operation discards in-flight work immediately
    issue(1, 5'd0, 32'd9, 32'd9, 0, 0);
    issue(1, 5'd2, 32'hFF, 32'h0F, 0, 0);
    reset = 1'b1;
    #1;
    check_zero_outputs("reset_mid_run");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(1, 5'd17, 32'hF000, 32'h000F, 0, 0);
    issue(0, 5'd0, 0, 0, 0, 0);
    check("ori_after_reset", {mem_valid, mem_result}, {1'b1, 32'hF00F});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
